vga_pixel_engine: RTL and testbench

//   Memory-mapped VGA drawing peripheral between proc (dout/realaddr/W) and vga_adapter.

---
 rtl/vga_pixel_engine.sv | 197 +++++++++++++++++++
 tb/tb_vga_pixel_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_engine.sv
// Memory-mapped VGA drawing peripheral: register file, pixel command FIFO and
// rectangle-fill engine feeding a single plot strobe per clock to vga_adapter.
module vga_pixel_engine #(
  parameter int XW    = 16,
  parameter int YW    = 16,
  parameter int CW    = 9,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cs,
  input  logic [4:0]    addr,
  input  logic          W,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_colour,
  output logic          plot
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = XW + YW + CW;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, fx0_q, fx0_d, plot_x_q, plot_x_d;
  logic [YW-1:0]   y_q, y_d, fy0_q, fy0_d, plot_y_q, plot_y_d;
  logic [CW-1:0]   col_q, col_d, fcol_q, fcol_d, plot_colour_q, plot_colour_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d, plot_q, plot_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [15:0]     fw_q, fw_d, fh_q, fh_d, cx_q, cx_d, cy_q, cy_d;

  logic wr, rd, a_push, a_stat, a_fill;
  logic push_ok, push_rej, fill_ok, fill_rej, pop, full, busy;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    col_d         = col_q;
    fx0_d         = fx0_q;
    fy0_d         = fy0_q;
    fcol_d        = fcol_q;
    fw_d          = fw_q;
    fh_d          = fh_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ovf_d         = ovf_q;
    rdata_d       = rdata_q;
    plot_x_d      = plot_x_q;
    plot_y_d      = plot_y_q;
    plot_colour_d = plot_colour_q;
    plot_d        = 1'b0;

    wr     = cs & W;
    rd     = cs & ~W;
    a_push = (addr == 5'h0C);
    a_stat = (addr == 5'h10);
    a_fill = (addr == 5'h14);
    full   = (count_q == DEPTH_C);
    busy   = (state_q != IDLE) | (count_q != '0);

    if (wr && addr == 5'h00) x_d   = wdata[XW-1:0];
    if (wr && addr == 5'h04) y_d   = wdata[YW-1:0];
    if (wr && addr == 5'h08) col_d = wdata[CW-1:0];

    // A pop in the same cycle does not make room for a push into a full FIFO.
    push_ok  = wr & a_push & (count_q < DEPTH_C);
    push_rej = wr & a_push & ~push_ok;
    fill_ok  = wr & a_fill & (state_q == IDLE) & (count_q == '0);
    fill_rej = wr & a_fill & ~fill_ok;
    pop      = (state_q == DRAIN) & (count_q != '0);

    if (push_ok) begin
      mem_d[wr_ptr_q] = {x_q, y_q, col_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      {plot_x_d, plot_y_d, plot_colour_d} = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      plot_d   = 1'b1;
    end
    count_d = count_q + CNTW'(push_ok) - CNTW'(pop);

    // Set beats clear when both happen on the same edge.
    if (wr && a_stat && wdata[2]) ovf_d = 1'b0;
    if (push_rej || fill_rej)     ovf_d = 1'b1;

    if (rd) begin
      case (addr)
        5'h00:   rdata_d = 32'(x_q);
        5'h04:   rdata_d = 32'(y_q);
        5'h08:   rdata_d = 32'(col_q);
        5'h10:   rdata_d = 32'({count_q, ovf_q, full, busy});
        default: rdata_d = '0;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (fill_ok && wdata[15:0] != '0 && wdata[31:16] != '0) begin
          fx0_d   = x_q;
          fy0_d   = y_q;
          fcol_d  = col_q;
          fw_d    = wdata[15:0];
          fh_d    = wdata[31:16];
          cx_d    = '0;
          cy_d    = '0;
          state_d = FILL;
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_d == '0) state_d = IDLE;
      end
      FILL: begin
        plot_d        = 1'b1;
        plot_x_d      = fx0_q + XW'(cx_q);
        plot_y_d      = fy0_q + YW'(cy_q);
        plot_colour_d = fcol_q;
        if (cx_q == fw_q - 16'd1) begin
          cx_d = '0;
          if (cy_q == fh_q - 16'd1) state_d = (count_d != '0) ? DRAIN : IDLE;
          else                      cy_d = cy_q + 16'd1;
        end else begin
          cx_d = cx_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      col_q         <= '0;
      fx0_q         <= '0;
      fy0_q         <= '0;
      fcol_q        <= '0;
      fw_q          <= '0;
      fh_q          <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      rdata_q       <= '0;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
      plot_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      col_q         <= col_d;
      fx0_q         <= fx0_d;
      fy0_q         <= fy0_d;
      fcol_q        <= fcol_d;
      fw_q          <= fw_d;
      fh_q          <= fh_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      rdata_q       <= rdata_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
      plot_q        <= plot_d;
    end
  end

  assign rdata       = rdata_q;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_colour = plot_colour_q;
  assign plot        = plot_q;
endmodule

// File: tb/tb_vga_pixel_engine.sv
// Bench for vga_pixel_engine: bus tasks drive register accesses, expected pixels
// go into a queue and are matched against every plot strobe seen on the output.
module tb_vga_pixel_engine;
  localparam int XW = 16, YW = 16, CW = 9, DEPTH = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cs, W;
  logic [4:0]    addr;
  logic [31:0]   wdata, rdata;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;
  logic [CW-1:0] plot_colour;
  logic          plot;

  typedef logic [XW+YW+CW-1:0] pix_t;
  pix_t exp_q[$];
  int checks = 0, errors = 0, plots_seen = 0;

  vga_pixel_engine #(.XW(XW), .YW(YW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .cs(cs), .addr(addr), .W(W), .wdata(wdata),
    .rdata(rdata), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .plot(plot)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and score any pixel emitted on the last rising edge.
  task automatic tick();
    pix_t e;
    @(negedge clk);
    if (plot !== 1'b0) begin
      plots_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got plot=%b (%h,%h,%h), required no plot",
                 plot, plot_x, plot_y, plot_colour);
      end else begin
        e = exp_q.pop_front();
        if ({plot_x, plot_y, plot_colour} !== e) begin
          errors++;
          $display("FAIL pixel: got (%h,%h,%h), required (%h,%h,%h)", plot_x, plot_y,
                   plot_colour, e[XW+YW+CW-1 -: XW], e[YW+CW-1 -: YW], e[CW-1:0]);
        end
      end
    end
  endtask

  task automatic expect_pix(input logic [XW-1:0] x, input logic [YW-1:0] y,
                            input logic [CW-1:0] c);
    exp_q.push_back({x, y, c});
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; W = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; W = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; W = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pixels still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    checks++;
    if (plot !== 1'b0 || plot_x !== '0 || plot_y !== '0 || plot_colour !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got plot=%b x=%h y=%h c=%h rdata=%h, required all 0",
               plot, plot_x, plot_y, plot_colour, rdata);
    end
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, required 0", r); end
    bus_read(5'h00, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_x: got %h, required 0", r); end
  endtask

  task automatic test_single();
    logic [31:0] r;
    bus_write(5'h00, 32'd5);
    bus_write(5'h04, 32'd7);
    bus_write(5'h08, 32'h1FF);
    bus_read(5'h08, r);
    checks++;
    if (r !== 32'h1FF) begin errors++; $display("FAIL single_col_rb: got %h, required 1ff", r); end
    expect_pix(16'd5, 16'd7, 9'h1FF);
    bus_write(5'h0C, 32'hDEAD_BEEF);
    wait_drain("single", 10);
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL single_status: got %h, required 0", r); end
    bus_read(5'h00, r);
    checks++;
    if (r !== 32'd5) begin errors++; $display("FAIL single_x_kept: got %h, required 5", r); end
  endtask

  // A long fill holds the FIFO undrained so back-to-back pushes reach overflow.
  task automatic test_back_to_back();
    logic [31:0] r;
    bus_write(5'h00, 32'd200);
    bus_write(5'h04, 32'd50);
    bus_write(5'h08, 32'h055);
    for (int i = 0; i < 40; i++) expect_pix(16'(200 + i), 16'd50, 9'h055);
    bus_write(5'h14, {16'd1, 16'd40});
    bus_write(5'h08, 32'h123);
    for (int i = 0; i <= DEPTH; i++) begin
      bus_write(5'h00, 32'(100 + i));
      if (i < DEPTH) expect_pix(16'(100 + i), 16'd50, 9'h123);
      bus_write(5'h0C, 32'h0);
    end
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h47) begin errors++; $display("FAIL b2b_status_full: got %h, required 47", r); end
    wait_drain("b2b", 100);
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h04) begin errors++; $display("FAIL b2b_ovf: got %h, required 4", r); end
    bus_write(5'h10, 32'h4);
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL b2b_ovf_clear: got %h, required 0", r); end
  endtask

  task automatic test_fill();
    int run, max_run;
    bus_write(5'h00, 32'd10);
    bus_write(5'h04, 32'd20);
    bus_write(5'h08, 32'h0AA);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 3; x++) expect_pix(16'(10 + x), 16'(20 + y), 9'h0AA);
    bus_write(5'h14, {16'd2, 16'd3});
    run = 0; max_run = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      run = (plot === 1'b1) ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    checks++;
    if (max_run != 6) begin errors++; $display("FAIL fill_consecutive: got run %0d, required 6", max_run); end
    wait_drain("fill", 5);
  endtask

  task automatic test_fill_reject();
    logic [31:0] r;
    bus_write(5'h00, 32'd1);
    bus_write(5'h04, 32'd1);
    expect_pix(16'd1, 16'd1, 9'h0AA);
    bus_write(5'h0C, 32'h0);
    bus_write(5'h14, {16'd2, 16'd2});
    wait_drain("reject", 10);
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h04) begin errors++; $display("FAIL reject_ovf: got %h, required 4", r); end
    bus_write(5'h10, 32'h4);
    bus_write(5'h14, {16'd4, 16'd0});
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL zero_fill_status: got %h, required 0", r); end
    repeat (6) tick();
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL zero_fill_idle: got %h, required 0", r); end
  endtask

  task automatic test_wrap();
    bus_write(5'h00, 32'hFFFF);
    bus_write(5'h04, 32'd3);
    bus_write(5'h08, 32'h101);
    expect_pix(16'hFFFF, 16'd3, 9'h101);
    expect_pix(16'h0000, 16'd3, 9'h101);
    bus_write(5'h14, {16'd1, 16'd2});
    wait_drain("wrap", 10);
  endtask

  task automatic test_regs();
    logic [31:0] r;
    bus_write(5'h00, 32'hABCD_1234);
    bus_write(5'h08, 32'hFFFF_FFFF);
    bus_write(5'h18, 32'h5555_5555);
    bus_read(5'h00, r);
    checks++;
    if (r !== 32'h1234) begin errors++; $display("FAIL regs_x: got %h, required 1234", r); end
    bus_read(5'h08, r);
    checks++;
    if (r !== 32'h1FF) begin errors++; $display("FAIL regs_col_mask: got %h, required 1ff", r); end
    bus_read(5'h0C, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL regs_push_rd: got %h, required 0", r); end
    bus_read(5'h18, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL regs_unmapped: got %h, required 0", r); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    int start;
    bus_write(5'h00, 32'd300);
    bus_write(5'h04, 32'd400);
    bus_write(5'h08, 32'h00F);
    for (int i = 0; i < 100; i++) expect_pix(16'(300 + i), 16'd400, 9'h00F);
    bus_write(5'h14, {16'd100, 16'd100});
    start = plots_seen;
    for (int i = 0; i < 50 && plots_seen - start < 10; i++) tick();
    checks++;
    if (plots_seen - start != 10) begin
      errors++;
      $display("FAIL abort_plots: got %0d plots, required 10", plots_seen - start);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b0 || rdata !== '0 || plot_x !== '0) begin
      errors++;
      $display("FAIL abort_async: got plot=%b rdata=%h x=%h, required 0", plot, rdata, plot_x);
    end
    exp_q.delete();
    tick();
    resetn = 1'b1;
    bus_read(5'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL abort_status: got %h, required 0", r); end
    bus_read(5'h00, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL abort_x: got %h, required 0", r); end
    repeat (5) tick();
  endtask

  initial begin
    cs = 1'b0; W = 1'b0; addr = '0; wdata = '0; resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_fill_reject();
    test_wrap();
    test_regs();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
